nibble_serial_alu_ctrl: RTL and testbench
=========================================

// Module: nibble_serial_alu_ctrl
// PURPOSE
//  Multi-cycle sequencer that computes a WIDTH-bit ALU op by driving one 4-bit look-ahead slice
//  once per cycle, LS nibble first, chaining carry through a register. Area-saving ALU option for
//  the RV32I core; sits between decode/issue (request side) and writeback (result side).
//  Valid/ready handshake on both sides; one operation in flight.
// PARAMETERS
//  WIDTH   32   operand/result width; multiple of 4, >= 8
//  NIB     WIDTH/4 (localparam) nibble count = RUN cycles per op
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      asynchronous active-high reset
//  req_valid_in in   1      request present
//  req_ready_out out 1      controller can accept (IDLE only)
//  op_in        in   3      0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SLT,6 SLTU,7 reserved
//  A_in         in   WIDTH  operand A
//  B_in         in   WIDTH  operand B
//  res_valid_out out 1      result valid (DONE)
//  res_ready_in in   1      consumer takes result
//  R_out        out  WIDTH  result
//  busy_out     out  1      high in RUN or DONE
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; R_out=0, res_valid_out=0, busy_out=0, counters/carry=0;
//    req_ready_out=1 from first clock after rst deasserts. In-flight op discarded, no result.
//  - FSM IDLE->RUN->DONE->IDLE. req_ready_out=(state==IDLE), combinational from state only.
//  - IDLE: on req_valid_in&req_ready_out latch A, Beff, op; cnt=0; carry=1 for SUB/SLT/SLTU else 0;
//    Beff=~B_in for SUB/SLT/SLTU else B_in. -> RUN. Inputs ignored outside IDLE.
//  - RUN cycle k (k=0..NIB-1): slice gets A[4k+:4], Beff[4k+:4], carry. Write R[4k+:4] = sum for
//    ADD/SUB, AND/OR/XOR slice output for logic ops, 0 for SLT/SLTU/reserved. carry<=slice C_out.
//    k==NIB-1 -> DONE; on that edge also fix SLT/SLTU bit 0 and flags.
//  - SLT: R=zero-extended (S[WIDTH-1] ^ V), V = (A[W-1]==Beff[W-1]) & (S[W-1]!=A[W-1]).
//    SLTU: R=zero-extended ~C_final. Reserved op: R=0.
//  - Latency: accept edge + NIB RUN cycles; res_valid_out high from edge NIB+1 after accept (9 for
//    WIDTH=32). Throughput one op per NIB+2 cycles minimum (accept/return both need IDLE/DONE).
//  - DONE: res_valid_out=1, R_out stable until res_valid_out&res_ready_in; then -> IDLE. No
//    accept in the same cycle as result return. R_out holds last value in IDLE (not cleared).
//  - cnt is $clog2(NIB) bits; never wraps (leaves RUN at NIB-1).
// CONFIGURATION
//  ALU_FLAGS_EN defined: extra outputs zero_out, carry_out, ovf_out (1b each), registered with
//   the DONE transition, valid with res_valid_out, reset 0. zero=(R==0); carry=C_final for
//   ADD/SUB/SLT/SLTU else 0; ovf=V for ADD/SUB else 0.
//  ALU_FLAGS_EN undefined: ports absent, no flag logic; results/timing identical.
// STRUCTURE
//  Package alu_ctrl_pkg: op encoding localparams (OP_ADD..OP_SLTU), FSM state typedef/encodings
//   (IDLE, RUN, DONE), NIB_W = $clog2(NIB).
//  One sub-module: alu_nibble_slice (combinational 4-bit G/P look-ahead add + AND/OR/XOR outputs),
//   instantiated once; this block holds FSM, operand/result registers, carry register, op decode.
// TESTING (WIDTH=32)
//  ADD 0x0000000F+0x00000001 -> R=0x00000010, res_valid_out 9 cycles after accept edge.
//  SUB 0x00000000-0x00000001 -> R=0xFFFFFFFF; flags build: carry=0, ovf=0, zero=0.
//  SLT A=0x80000000 B=1 -> R=1; SLTU same operands -> R=0; XOR 0xA5A5A5A5^0xFFFFFFFF -> 0x5A5A5A5A.
//  ADD 0x7FFFFFFF+1 -> R=0x80000000, ovf=1; ADD 0xFFFFFFFF+1 -> R=0, carry=1, zero=1.
//  Hold res_ready_in=0 5 cycles in DONE while req_valid_in=1 -> R_out stable, req_ready_out=0,
//   new request not taken; accepted only in IDLE after return.
//  Assert rst during RUN k=3 -> outputs 0 same cycle, IDLE; next op after release returns correct R.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the nibble-serial ALU controller: op codes, FSM states,
// default width and a helper for the nibble counter width.
package alu_ctrl_pkg;

  localparam int DEF_WIDTH = 32;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_SLT  = 3'd5;
  localparam logic [2:0] OP_SLTU = 3'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to count the WIDTH/4 nibbles of an operand.
  function automatic int nib_w(input int width);
    return $clog2(width / 4);
  endfunction

endpackage

// File: rtl/alu_nibble_slice.sv
// Combinational 4-bit slice: generate/propagate look-ahead adder plus the
// bitwise AND/OR/XOR results of the same operand nibbles.
module alu_nibble_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out,
  output logic [3:0] and_val,
  output logic [3:0] or_val,
  output logic [3:0] xor_val
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = c_in;
  assign c[1] = g[0] | (p[0] & c_in);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c_in);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c_in);

  assign sum     = p ^ c[3:0];
  assign c_out   = c[4];
  assign and_val = g;
  assign or_val  = a | b;
  assign xor_val = p;

endmodule

// File: rtl/nibble_serial_alu_ctrl.sv
// Sequencer that evaluates a WIDTH-bit ALU op one nibble per cycle through a
// single shared slice, carry chained in a register. Define ALU_FLAGS_EN for zero/carry/ovf outputs.
module nibble_serial_alu_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid_in,
  output logic             req_ready_out,
  input  logic [2:0]       op_in,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  output logic             res_valid_out,
  input  logic             res_ready_in,
  output logic [WIDTH-1:0] R_out,
  output logic             busy_out
`ifdef ALU_FLAGS_EN
  ,
  output logic             zero_out,
  output logic             carry_out,
  output logic             ovf_out
`endif
);

  localparam int NIB   = WIDTH / 4;
  localparam int NIB_W = nib_w(WIDTH);

  state_t state;
  state_t state_next;

  logic [NIB-1:0][3:0] a_reg;
  logic [NIB-1:0][3:0] b_reg;
  logic [NIB-1:0][3:0] r_reg;
  logic [NIB-1:0][3:0] r_final;
  logic [2:0]          op_reg;
  logic [NIB_W-1:0]    cnt;
  logic                carry;

  logic       accept;
  logic       last;
  logic       sub_like;
  logic       is_cmp;
  logic [3:0] sum;
  logic [3:0] and_val;
  logic [3:0] or_val;
  logic [3:0] xor_val;
  logic [3:0] nib_res;
  logic       c_out;
  logic       ovf;
  logic       lt_bit;

  assign sub_like = (op_in == OP_SUB) || (op_in == OP_SLT) || (op_in == OP_SLTU);
  assign is_cmp   = (op_reg == OP_SLT) || (op_reg == OP_SLTU);
  assign accept   = req_valid_in && req_ready_out;
  assign last     = (state == RUN) && (cnt == NIB_W'(NIB - 1));

  alu_nibble_slice u_slice (
    .a       (a_reg[cnt]),
    .b       (b_reg[cnt]),
    .c_in    (carry),
    .sum     (sum),
    .c_out   (c_out),
    .and_val (and_val),
    .or_val  (or_val),
    .xor_val (xor_val)
  );

  // NOTE: sequential state uses non-blocking assignment so every register
  // samples the pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next    = state;
    req_ready_out = 1'b0;
    res_valid_out = 1'b0;
    busy_out      = 1'b0;
    case (state)
      IDLE: begin
        req_ready_out = 1'b1;
        if (req_valid_in) state_next = RUN;
      end
      RUN: begin
        busy_out = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        busy_out      = 1'b1;
        res_valid_out = 1'b1;
        if (res_ready_in) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    nib_res = 4'h0;
    case (op_reg)
      OP_ADD, OP_SUB: nib_res = sum;
      OP_AND:         nib_res = and_val;
      OP_OR:          nib_res = or_val;
      OP_XOR:         nib_res = xor_val;
      default:        nib_res = 4'h0;
    endcase
  end

  // Sign/overflow terms are only meaningful while the top nibble is in the slice.
  assign ovf = (a_reg[NIB-1][3] == b_reg[NIB-1][3]) && (sum[3] != a_reg[NIB-1][3]);

  always_comb begin
    lt_bit = 1'b0;
    if (op_reg == OP_SLT)  lt_bit = sum[3] ^ ovf;
    if (op_reg == OP_SLTU) lt_bit = ~c_out;
  end

  always_comb begin
    r_final          = r_reg;
    r_final[NIB-1]   = nib_res;
    if (is_cmp) r_final[0][0] = lt_bit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg  <= '0;
      b_reg  <= '0;
      r_reg  <= '0;
      op_reg <= OP_ADD;
      cnt    <= '0;
      carry  <= 1'b0;
    end else if (accept) begin
      a_reg  <= A_in;
      b_reg  <= sub_like ? ~B_in : B_in;
      op_reg <= op_in;
      cnt    <= '0;
      carry  <= sub_like;
    end else if (state == RUN) begin
      carry <= c_out;
      if (last) begin
        r_reg <= r_final;
      end else begin
        r_reg[cnt] <= nib_res;
        cnt        <= cnt + 1'b1;
      end
    end
  end

  assign R_out = r_reg;

`ifdef ALU_FLAGS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_out  <= 1'b0;
      carry_out <= 1'b0;
      ovf_out   <= 1'b0;
    end else if (last) begin
      zero_out  <= (r_final == '0);
      carry_out <= (op_reg == OP_ADD) || (op_reg == OP_SUB) || is_cmp ? c_out : 1'b0;
      ovf_out   <= (op_reg == OP_ADD) || (op_reg == OP_SUB) ? ovf : 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_nibble_serial_alu_ctrl.sv
// Self-checking bench: directed vector table, random ops against an arithmetic
// reference model, and hand sequences for DONE back-pressure and mid-run reset.
module tb_nibble_serial_alu_ctrl;
  import alu_ctrl_pkg::*;

  localparam int W       = 32;
  localparam int EXP_LAT = W / 4 + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid_in;
  logic         req_ready_out;
  logic [2:0]   op_in;
  logic [W-1:0] A_in;
  logic [W-1:0] B_in;
  logic         res_valid_out;
  logic         res_ready_in;
  logic [W-1:0] R_out;
  logic         busy_out;
`ifdef ALU_FLAGS_EN
  logic         zero_out;
  logic         carry_out;
  logic         ovf_out;
`endif

  int tests  = 0;
  int failed = 0;

  nibble_serial_alu_ctrl #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid_in  (req_valid_in),
    .req_ready_out (req_ready_out),
    .op_in         (op_in),
    .A_in          (A_in),
    .B_in          (B_in),
    .res_valid_out (res_valid_out),
    .res_ready_in  (res_ready_in),
    .R_out         (R_out),
    .busy_out      (busy_out)
`ifdef ALU_FLAGS_EN
    ,
    .zero_out      (zero_out),
    .carry_out     (carry_out),
    .ovf_out       (ovf_out)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic         c;
    logic         v;
    logic         z;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: results and flags straight from two's-complement arithmetic.
  function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic c, output logic v,
                                output logic z);
    logic [W:0] ext;
    c = 1'b0;
    v = 1'b0;
    case (op)
      OP_ADD: begin
        ext = {1'b0, a} + {1'b0, b};
        r   = ext[W-1:0];
        c   = ext[W];
        v   = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      OP_SUB: begin
        r = a - b;
        c = (a >= b);
        v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLT: begin
        r = ($signed(a) < $signed(b)) ? 1 : 0;
        c = (a >= b);
      end
      OP_SLTU: begin
        r = (a < b) ? 1 : 0;
        c = (a >= b);
      end
      default: r = '0;
    endcase
    z = (r == '0);
  endfunction

  // Called at a negedge in IDLE; returns at the negedge after the accept edge.
  task automatic start_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    check("ready_before_req", req_ready_out, 1'b1);
    req_valid_in = 1'b1;
    op_in        = op;
    A_in         = a;
    B_in         = b;
    @(posedge clk);
    @(negedge clk);
    req_valid_in = 1'b0;
    op_in        = $urandom_range(0, 7);
    A_in         = $urandom;
    B_in         = $urandom;
  endtask

  // Waits for the result (accept edge counts as edge 1), checks it, optionally retires it.
  task automatic finish_op(input string tag, input logic [W-1:0] er, input logic ec,
                           input logic ev, input logic ez, input bit retire);
    int edges = 1;
    while (!res_valid_out && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check({tag, "_latency"}, edges, EXP_LAT);
    check({tag, "_R"}, R_out, er);
    check({tag, "_busy"}, busy_out, 1'b1);
`ifdef ALU_FLAGS_EN
    check({tag, "_carry"}, carry_out, ec);
    check({tag, "_ovf"}, ovf_out, ev);
    check({tag, "_zero"}, zero_out, ez);
`else
    if (ec === 1'bx || ev === 1'bx || ez === 1'bx) check({tag, "_model_x"}, 1, 0);
`endif
    if (retire) begin
      res_ready_in = 1'b1;
      @(posedge clk);
      @(negedge clk);
      res_ready_in = 1'b0;
      check({tag, "_retired"}, {res_valid_out, req_ready_out, busy_out}, 3'b010);
    end
  endtask

  initial begin
    logic [W-1:0] r, held_r;
    logic         c, v, z;
    logic [2:0]   rop;
    logic [W-1:0] ra, rb;
    logic [W-1:0] edge_vals[5];

    vecs[0]  = '{OP_ADD,  32'h0000000F, 32'h00000001, 32'h00000010, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{OP_SUB,  32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{OP_SLT,  32'h80000000, 32'h00000001, 32'h00000001, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{OP_SLTU, 32'h80000000, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{OP_XOR,  32'hA5A5A5A5, 32'hFFFFFFFF, 32'h5A5A5A5A, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{OP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{OP_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{OP_AND,  32'hF0F0FF00, 32'h3C3C0FF0, 32'h30300F00, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{OP_OR,   32'h12340000, 32'h00005678, 32'h12345678, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{3'd7,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{OP_SUB,  32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{OP_SLT,  32'h00000001, 32'h80000000, 32'h00000000, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{OP_SLTU, 32'h00000001, 32'h80000000, 32'h00000001, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{OP_SLT,  32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{OP_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};

    rst          = 1'b1;
    req_valid_in = 1'b0;
    res_ready_in = 1'b0;
    op_in        = '0;
    A_in         = '0;
    B_in         = '0;

    repeat (2) @(negedge clk);
    check("reset_state", {R_out, res_valid_out, busy_out}, '0);
`ifdef ALU_FLAGS_EN
    check("reset_flags", {zero_out, carry_out, ovf_out}, 3'b000);
`endif
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("ready_after_reset", {req_ready_out, res_valid_out, busy_out}, 3'b100);

    for (int i = 0; i < 15; i++) begin
      start_op(vecs[i].op, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d_busy_run", i), {busy_out, req_ready_out, res_valid_out}, 3'b100);
      finish_op($sformatf("vec%0d", i), vecs[i].r, vecs[i].c, vecs[i].v, vecs[i].z, 1'b1);
      check($sformatf("vec%0d_R_held_idle", i), R_out, vecs[i].r);
    end

    edge_vals = '{32'h00000000, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h00000001};
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : $urandom;
      model(rop, ra, rb, r, c, v, z);
      start_op(rop, ra, rb);
      finish_op($sformatf("rand%0d_op%0d", i, rop), r, c, v, z, 1'b1);
    end

    // Back-pressure in DONE with a competing request pending.
    model(OP_ADD, 32'h12345678, 32'h11111111, r, c, v, z);
    held_r = r;
    start_op(OP_ADD, 32'h12345678, 32'h11111111);
    finish_op("hold_first", r, c, v, z, 1'b0);
    req_valid_in = 1'b1;
    op_in        = OP_XOR;
    A_in         = 32'hDEADBEEF;
    B_in         = 32'h0F0F0F0F;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("hold%0d_R_stable", k), R_out, held_r);
      check($sformatf("hold%0d_valid_ready", k), {res_valid_out, req_ready_out}, 2'b10);
    end
    res_ready_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready_in = 1'b0;
    check("hold_not_taken_on_return", {res_valid_out, req_ready_out, busy_out}, 3'b010);
    @(posedge clk);
    @(negedge clk);
    req_valid_in = 1'b0;
    check("hold_taken_in_idle", {busy_out, req_ready_out}, 2'b10);
    finish_op("hold_second", 32'hDEADBEEF ^ 32'h0F0F0F0F, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset while the fourth nibble (k=3) is in the slice.
    start_op(OP_ADD, 32'h11111111, 32'h11111111);
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("midrun_partial_R", R_out[11:0], 12'h222);
    #2 rst = 1'b1;
    #1;
    check("midrun_reset_outputs", {R_out, res_valid_out, busy_out}, '0);
    check("midrun_reset_idle", req_ready_out, 1'b1);
`ifdef ALU_FLAGS_EN
    check("midrun_reset_flags", {zero_out, carry_out, ovf_out}, 3'b000);
`endif
    @(negedge clk);
    rst = 1'b0;
    repeat (12) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("midrun_no_result", {res_valid_out, busy_out, req_ready_out}, 3'b001);
    model(OP_SUB, 32'h00001000, 32'h00000001, r, c, v, z);
    start_op(OP_SUB, 32'h00001000, 32'h00000001);
    finish_op("after_reset", r, c, v, z, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
